// File: rtl/apb2axi_pkg.sv
// Shared types and default sizes for the APB-to-AXI bridge read path.
package apb2axi_pkg;

  localparam int TAG_NUM                = 16;
  localparam int TAG_W                  = (TAG_NUM > 1) ? $clog2(TAG_NUM) : 1;
  localparam int MAX_BEATS_NUM          = 16;
  localparam int AXI_DATA_W             = 64;
  localparam int APB_DATA_W             = 32;
  localparam int APB_WORDS_PER_AXI_BEAT = AXI_DATA_W / APB_DATA_W;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    RB_EMPTY   = 2'd0,
    RB_FILLING = 2'd1,
    RB_DONE    = 2'd2
  } rdbuf_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [AXI_DATA_W-1:0] data;
    logic                  last;
    axi_resp_e             resp;
  } rdf_entry_t;

  function automatic logic is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/apb2axi_rdbuf_tag_ctrl.sv
// Per-tag lifecycle (EMPTY/FILLING/DONE), write/read counters and error capture.
module apb2axi_rdbuf_tag_ctrl
  import apb2axi_pkg::*;
#(
  parameter int BEATS_P = 16,
  parameter int WORDS_P = 2,
  localparam int CNT_W  = $clog2(BEATS_P + 1),
  localparam int WIDX_W = (WORDS_P > 1) ? $clog2(WORDS_P) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              accept_i,
  input  logic              last_i,
  input  logic              resp_err_i,
  input  logic              pop_i,
  input  logic              release_i,
  output logic              store_o,
  output logic              word_valid_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  wr_cnt_o,
  output logic [CNT_W-1:0]  rd_beat_o,
  output logic [WIDX_W-1:0] word_idx_o,
  output logic [7:0]        err_beat_o
);

  rdbuf_state_e      state_q, state_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_beat_q, rd_beat_d;
  logic [WIDX_W-1:0] word_idx_q, word_idx_d;
  logic [7:0]        err_beat_q, err_beat_d;
  logic              err_q, err_d;
  logic              resp_seen_q, resp_seen_d;
  logic              full;

  assign full         = (wr_cnt_q == CNT_W'(BEATS_P));
  assign store_o      = accept_i & ~full;
  assign word_valid_o = (rd_beat_q < wr_cnt_q);
  assign done_o       = (state_q == RB_DONE);
  assign err_o        = err_q;
  assign wr_cnt_o     = wr_cnt_q;
  assign rd_beat_o    = rd_beat_q;
  assign word_idx_o   = word_idx_q;
  assign err_beat_o   = err_beat_q;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_beat_d   = rd_beat_q;
    word_idx_d  = word_idx_q;
    err_beat_d  = err_beat_q;
    err_d       = err_q;
    resp_seen_d = resp_seen_q;
    // Release only acts on a finished tag and overrides any pop in the same cycle.
    if (release_i && state_q == RB_DONE) begin
      state_d     = RB_EMPTY;
      wr_cnt_d    = '0;
      rd_beat_d   = '0;
      word_idx_d  = '0;
      err_beat_d  = '0;
      err_d       = 1'b0;
      resp_seen_d = 1'b0;
    end else begin
      if (accept_i) begin
        if (!full) wr_cnt_d = wr_cnt_q + 1'b1;
        else       err_d    = 1'b1;
        if (resp_err_i) begin
          err_d = 1'b1;
          if (!resp_seen_q) begin
            resp_seen_d = 1'b1;
            err_beat_d  = 8'(wr_cnt_q);
          end
        end
        if (last_i)                    state_d = RB_DONE;
        else if (state_q == RB_EMPTY)  state_d = RB_FILLING;
      end
      if (pop_i && word_valid_o) begin
        if (word_idx_q == WIDX_W'(WORDS_P - 1)) begin
          word_idx_d = '0;
          rd_beat_d  = rd_beat_q + 1'b1;
        end else begin
          word_idx_d = word_idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RB_EMPTY;
      wr_cnt_q    <= '0;
      rd_beat_q   <= '0;
      word_idx_q  <= '0;
      err_beat_q  <= '0;
      err_q       <= 1'b0;
      resp_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_beat_q   <= rd_beat_d;
      word_idx_q  <= word_idx_d;
      err_beat_q  <= err_beat_d;
      err_q       <= err_d;
      resp_seen_q <= resp_seen_d;
    end
  end

endmodule

// File: rtl/apb2axi_rd_buffer.sv
// Tag-indexed AXI read-data buffer serving APB-width words per selected tag.
// Build option: APB2AXI_RDBUF_ERR_SQUASH_EN stores non-OKAY beats as all-zero data.
module apb2axi_rd_buffer
  import apb2axi_pkg::*;
#(
  parameter int TAG_NUM_P = 16,
  parameter int BEATS_P   = MAX_BEATS_NUM,
  parameter int AXI_DW    = AXI_DATA_W,
  parameter int APB_DW    = APB_DATA_W,
  localparam int TAG_BITS = (TAG_NUM_P > 1) ? $clog2(TAG_NUM_P) : 1,
  localparam int RATIO    = AXI_DW / APB_DW,
  localparam int CNT_W    = $clog2(BEATS_P + 1),
  localparam int WIDX_W   = (RATIO > 1) ? $clog2(RATIO) : 1,
  localparam int BIDX_W   = (BEATS_P > 1) ? $clog2(BEATS_P) : 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 rdf_valid,
  output logic                 rdf_ready,
  input  logic [TAG_BITS-1:0]  rdf_tag,
  input  logic [AXI_DW-1:0]    rdf_data,
  input  logic                 rdf_last,
  input  logic [1:0]           rdf_resp,
  input  logic [TAG_BITS-1:0]  rd_sel_tag,
  input  logic                 rd_pop,
  output logic [APB_DW-1:0]    rd_word,
  output logic                 rd_word_valid,
  output logic [7:0]           rd_beats,
  output logic [7:0]           rd_err_beat,
  output logic [TAG_NUM_P-1:0] done_map,
  output logic [TAG_NUM_P-1:0] err_map,
  input  logic                 rel_valid,
  input  logic [TAG_BITS-1:0]  rel_tag
);

  if ((AXI_DW % APB_DW) != 0 || !is_pow2(RATIO)) begin : g_bad_ratio
    $error("apb2axi_rd_buffer: AXI_DW/APB_DW must be a power of 2");
  end

  logic [TAG_NUM_P-1:0] accept_v, pop_v, rel_v, store_v, wvalid_v;
  logic [CNT_W-1:0]     wr_cnt_a   [TAG_NUM_P];
  logic [CNT_W-1:0]     rd_beat_a  [TAG_NUM_P];
  logic [WIDX_W-1:0]    word_idx_a [TAG_NUM_P];
  logic [7:0]           err_beat_a [TAG_NUM_P];

  logic [AXI_DW-1:0]    mem_q [TAG_NUM_P][BEATS_P];
  logic                 resp_err;
  logic [AXI_DW-1:0]    wr_data;
  logic [BIDX_W-1:0]    wr_idx;
  logic [BIDX_W-1:0]    rd_idx;
  logic [AXI_DW-1:0]    rd_beat_data;
  logic [APB_DW-1:0]    beat_words [RATIO];

  assign resp_err  = (axi_resp_e'(rdf_resp) != RESP_OKAY);
  assign rdf_ready = aresetn & ~done_map[rdf_tag];

  for (genvar gi = 0; gi < TAG_NUM_P; gi++) begin : g_tag
    assign accept_v[gi] = rdf_valid & rdf_ready & (rdf_tag == TAG_BITS'(gi));
    assign pop_v[gi]    = rd_pop & (rd_sel_tag == TAG_BITS'(gi));
    assign rel_v[gi]    = rel_valid & (rel_tag == TAG_BITS'(gi));

    apb2axi_rdbuf_tag_ctrl #(
      .BEATS_P (BEATS_P),
      .WORDS_P (RATIO)
    ) u_tag_ctrl (
      .clk_i        (aclk),
      .rst_ni       (aresetn),
      .accept_i     (accept_v[gi]),
      .last_i       (rdf_last),
      .resp_err_i   (resp_err),
      .pop_i        (pop_v[gi]),
      .release_i    (rel_v[gi]),
      .store_o      (store_v[gi]),
      .word_valid_o (wvalid_v[gi]),
      .done_o       (done_map[gi]),
      .err_o        (err_map[gi]),
      .wr_cnt_o     (wr_cnt_a[gi]),
      .rd_beat_o    (rd_beat_a[gi]),
      .word_idx_o   (word_idx_a[gi]),
      .err_beat_o   (err_beat_a[gi])
    );
  end

`ifdef APB2AXI_RDBUF_ERR_SQUASH_EN
  assign wr_data = resp_err ? '0 : rdf_data;
`else
  assign wr_data = rdf_data;
`endif

  // Storage has no reset; visibility is governed purely by the per-tag counters.
  assign wr_idx = wr_cnt_a[rdf_tag][BIDX_W-1:0];
  always_ff @(posedge aclk) begin
    if (|store_v) mem_q[rdf_tag][wr_idx] <= wr_data;
  end

  assign rd_idx       = rd_beat_a[rd_sel_tag][BIDX_W-1:0];
  assign rd_beat_data = mem_q[rd_sel_tag][rd_idx];

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_word
    assign beat_words[gi] = rd_beat_data[gi*APB_DW +: APB_DW];
  end

  assign rd_word_valid = wvalid_v[rd_sel_tag];
  assign rd_word       = rd_word_valid ? beat_words[word_idx_a[rd_sel_tag]] : '0;
  assign rd_beats      = 8'(wr_cnt_a[rd_sel_tag]);
  assign rd_err_beat   = err_beat_a[rd_sel_tag];

endmodule
